// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and the round-robin grant helper.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int REG_DATA_W    = 32;
  localparam int NUM_ARCH_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  localparam int MAX_REQ       = 4;

  // One-hot grant for the first set req bit found starting at ptr and
  // walking upward modulo n; zero when no bit is set.
  function automatic logic [MAX_REQ-1:0] rrGrant(
    input logic [MAX_REQ-1:0] req,
    input int                 ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] grantVec;
    logic [1:0]         idx;
    grantVec = '0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = 2'((ptr + k) % n);
        if (req[idx]) begin
          grantVec      = '0;
          grantVec[idx] = 1'b1;
        end
      end
    end
    return grantVec;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter core: one-hot grant plus the pointer value to use next.
// Latency: purely combinational; the pointer register lives in the parent.
// Backpressure: none; grants whenever any request is present.
module rr_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] nextPointer
);

  logic [MAX_REQ-1:0] reqWide;
  logic [MAX_REQ-1:0] grantWide;

  // Widen requests for the shared helper and move the pointer past the winner.
  always_comb begin
    reqWide        = '0;
    reqWide[N-1:0] = req;
    grantWide      = rrGrant(reqWide, int'(pointer), N);
    grant          = grantWide[N-1:0];
    nextPointer    = pointer;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (grantWide[i]) nextPointer = PTR_W'((i + 1) % N);
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources via one-deep slots.
// Latency: accepted at edge k, write stage loaded at k+1, register file updated at k+2.
// Backpressure: ReqReady drops only while a slot is full and not granted; write port never stalls.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      Clock,
  input  logic                      CleanAllControl,
  input  logic [NUM_REQ-1:0]        ReqValid,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] ReqData,
  output logic [NUM_REQ-1:0]        ReqReady,
  output logic [ADDR_W-1:0]         WriteRegAddress,
  output logic [DATA_W-1:0]         DataOfWrite,
  output logic                      WriteControl,
  output logic [NUM_ARCH_REGS-1:0]  PendingRegs,
  output logic                      Idle
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] slotValid;
  logic [ADDR_W-1:0]  slotAddr [NUM_REQ];
  logic [DATA_W-1:0]  slotData [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   rrPointer;
  logic [PTR_W-1:0]   rrNextPointer;
  logic               wrValid;
  logic [ADDR_W-1:0]  wrAddr;
  logic [DATA_W-1:0]  wrData;
  logic [ADDR_W-1:0]  grantAddr;
  logic [DATA_W-1:0]  grantData;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) uArbiter (
    .req         (slotValid),
    .pointer     (rrPointer),
    .grant       (grant),
    .nextPointer (rrNextPointer)
  );

  // A slot accepts when empty or when its entry leaves on this same edge.
  assign ReqReady = ~slotValid | grant;

  // Mux the granted slot's contents toward the write stage (grant is one-hot or zero).
  always_comb begin
    grantAddr = '0;
    grantData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grantAddr = slotAddr[i];
        grantData = slotData[i];
      end
    end
  end

  // Holding slots: capture on handshake (refill wins over drain), empty when drained alone.
  always_ff @(posedge Clock or negedge CleanAllControl) begin
    if (!CleanAllControl) begin
      slotValid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slotAddr[i] <= '0;
        slotData[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ReqValid[i] && ReqReady[i]) begin
          slotValid[i] <= 1'b1;
          slotAddr[i]  <= ReqAddr[i*ADDR_W +: ADDR_W];
          slotData[i]  <= ReqData[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          slotValid[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer moves past each winner and holds when nobody is granted.
  always_ff @(posedge Clock or negedge CleanAllControl) begin
    if (!CleanAllControl) begin
      rrPointer <= '0;
    end else if (|grant) begin
      rrPointer <= rrNextPointer;
    end
  end

  // Write stage: reloaded every edge; address/data hold when idle to avoid needless toggling.
  always_ff @(posedge Clock or negedge CleanAllControl) begin
    if (!CleanAllControl) begin
      wrValid <= 1'b0;
      wrAddr  <= '0;
      wrData  <= '0;
    end else begin
      wrValid <= |grant;
      if (|grant) begin
        wrAddr <= grantAddr;
        wrData <= grantData;
      end
    end
  end

  // Bitmap of registers with a write still in flight, for decode's RAW stall.
  always_comb begin
    PendingRegs = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (slotValid[i]) PendingRegs[slotAddr[i]] = 1'b1;
    end
    if (wrValid) PendingRegs[wrAddr] = 1'b1;
    PendingRegs[REG_ZERO] = 1'b0;
  end

  // r0 writes still consume a grant and a write-stage slot but never enable the port.
  assign WriteRegAddress = wrAddr;
  assign DataOfWrite     = wrData;
  assign WriteControl    = wrValid && (wrAddr != ADDR_W'(REG_ZERO));
  assign Idle            = !(|slotValid) && !wrValid;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a queue-level reference model predicts
// readiness, pending bits and the exact edge of every register-file write.
module tb_regfile_write_arbiter;

  logic        Clock;
  logic        CleanAllControl;
  logic [1:0]  ReqValid;
  logic [9:0]  ReqAddr;
  logic [63:0] ReqData;
  logic [1:0]  ReqReady;
  logic [4:0]  WriteRegAddress;
  logic [31:0] DataOfWrite;
  logic        WriteControl;
  logic [31:0] PendingRegs;
  logic        Idle;

  regfile_write_arbiter #(
    .NUM_REQ (2),
    .DATA_W  (32),
    .ADDR_W  (5)
  ) dut (
    .Clock           (Clock),
    .CleanAllControl (CleanAllControl),
    .ReqValid        (ReqValid),
    .ReqAddr         (ReqAddr),
    .ReqData         (ReqData),
    .ReqReady        (ReqReady),
    .WriteRegAddress (WriteRegAddress),
    .DataOfWrite     (DataOfWrite),
    .WriteControl    (WriteControl),
    .PendingRegs     (PendingRegs),
    .Idle            (Idle)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } ent_t;

  // Reference model state: what each requester has handed over but not yet seen
  // drained, what sits in the write stage, and the expected write stream.
  ent_t        slotQ [2][$];
  ent_t        expQ [$];
  logic [4:0]  seenQ [$];
  int          rrPtr;
  logic        wrV;
  logic [4:0]  wrA;
  logic [31:0] expRf [32];
  logic [31:0] rf [32];
  int          edgeCnt = 0;
  int          nCmp = 0;
  int          nBad = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // The register file the arbiter feeds; cleared by the same reset net.
  always @(posedge Clock or negedge CleanAllControl) begin
    if (!CleanAllControl) begin
      for (int r = 0; r < 32; r++) rf[r] <= '0;
    end else if (WriteControl) begin
      rf[WriteRegAddress] <= DataOfWrite;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelPending();
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 2; i++) begin
      if (slotQ[i].size() != 0) p[slotQ[i][0].addr] = 1'b1;
    end
    if (wrV) p[wrA] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic clearModel();
    slotQ[0].delete();
    slotQ[1].delete();
    expQ.delete();
    rrPtr = 0;
    wrV   = 1'b0;
    wrA   = '0;
    for (int r = 0; r < 32; r++) expRf[r] = '0;
  endtask

  // Monitor: after every edge, retire overdue expectations and match each enabled write.
  initial begin
    ent_t e;
    forever begin
      @(posedge Clock);
      #1;
      edgeCnt++;
      while (expQ.size() != 0 && expQ[0].due < edgeCnt) begin
        nCmp++;
        nBad++;
        $display("FAIL missing_write: r%0d never written, expected at edge %0d", expQ[0].addr, expQ[0].due);
        void'(expQ.pop_front());
      end
      if (WriteControl === 1'b1) begin
        seenQ.push_back(WriteRegAddress);
        if (expQ.size() == 0) begin
          nCmp++;
          nBad++;
          $display("FAIL unexpected_write: r%0d data %0h at edge %0d", WriteRegAddress, DataOfWrite, edgeCnt);
        end else begin
          e = expQ.pop_front();
          chk("wr_addr", 64'(WriteRegAddress), 64'(e.addr));
          chk("wr_data", 64'(DataOfWrite), 64'(e.data));
          chk("wr_edge", 64'(edgeCnt), 64'(e.due));
        end
      end
    end
  end

  // One clock of stimulus: drive at negedge, check combinational outputs against the
  // model, then advance the model to the state the coming edge should produce.
  task automatic step(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1, output logic [1:0] acc);
    int         g;
    int         idx;
    logic [1:0] expRdy;
    ent_t       e;
    @(negedge Clock);
    ReqValid = v;
    ReqAddr  = {a1, a0};
    ReqData  = {d1, d0};
    #1;
    g = -1;
    for (int k = 0; k < 2; k++) begin
      idx = (rrPtr + k) % 2;
      if (g < 0 && slotQ[idx].size() != 0) g = idx;
    end
    for (int i = 0; i < 2; i++) expRdy[i] = (slotQ[i].size() == 0) || (g == i);
    chk("ready", 64'(ReqReady), 64'(expRdy));
    chk("pending", 64'(PendingRegs), 64'(modelPending()));
    chk("idle", 64'(Idle), 64'(slotQ[0].size() == 0 && slotQ[1].size() == 0 && !wrV));
    chk("wr_enable", 64'(WriteControl), 64'(wrV && wrA != 5'd0));
    wrV = 1'b0;
    if (g >= 0) begin
      e   = slotQ[g].pop_front();
      wrV = 1'b1;
      wrA = e.addr;
      if (e.addr != 5'd0) begin
        e.due = edgeCnt + 1;
        expQ.push_back(e);
        expRf[e.addr] = e.data;
      end
      rrPtr = (g + 1) % 2;
    end
    for (int i = 0; i < 2; i++) begin
      acc[i] = v[i] && expRdy[i];
      if (acc[i]) begin
        e.addr = (i == 0) ? a0 : a1;
        e.data = (i == 0) ? d0 : d1;
        e.due  = 0;
        slotQ[i].push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    logic [1:0] acc;
    for (int c = 0; c < n; c++) step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, acc);
  endtask

  // Asynchronous reset between edges, with requests held high to show nothing is captured.
  task automatic doReset(input logic [1:0] vDuring);
    #3;
    CleanAllControl = 1'b0;
    ReqValid        = vDuring;
    #1;
    chk("rst_wr_enable", 64'(WriteControl), 64'(0));
    chk("rst_pending", 64'(PendingRegs), 64'(0));
    chk("rst_idle", 64'(Idle), 64'(1));
    chk("rst_ready", 64'(ReqReady), 64'(2'b11));
    chk("rst_wr_addr", 64'(WriteRegAddress), 64'(0));
    chk("rst_wr_data", 64'(DataOfWrite), 64'(0));
    clearModel();
    repeat (2) @(negedge Clock);
    chk("rst_hold_idle", 64'(Idle), 64'(1));
    chk("rst_hold_pending", 64'(PendingRegs), 64'(0));
    chk("rst_hold_ready", 64'(ReqReady), 64'(2'b11));
    ReqValid        = 2'b00;
    CleanAllControl = 1'b1;
  endtask

  initial begin
    logic [1:0] acc;
    int         i0;
    int         i1;
    logic [4:0] expAddr;
    CleanAllControl = 1'b0;
    ReqValid        = 2'b11;
    ReqAddr         = {5'd3, 5'd2};
    ReqData         = '1;
    clearModel();
    doReset(2'b11);

    // Single write: pending from acceptance, enabled write one edge later.
    step(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, acc);
    idle(3);
    chk("rf_r5", 64'(rf[5]), 64'(32'hDEADBEEF));

    // Contention from a fresh pointer: strict alternation, no loss or duplication.
    doReset(2'b00);
    seenQ.delete();
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 40 && (i0 < 4 || i1 < 4); c++) begin
      step({i1 < 4, i0 < 4}, 5'(i0 + 1), 5'(i1 + 10), 32'h100 + 32'(i0), 32'h200 + 32'(i1), acc);
      if (acc[0]) i0++;
      if (acc[1]) i1++;
    end
    idle(3);
    chk("rr_count", 64'(seenQ.size()), 64'(8));
    for (int j = 0; j < 8 && j < seenQ.size(); j++) begin
      expAddr = (j % 2 == 0) ? 5'(j / 2 + 1) : 5'(j / 2 + 10);
      chk($sformatf("rr_order_%0d", j), 64'(seenQ[j]), 64'(expAddr));
    end

    // r0 write: accepted and granted, never enabled, never pending.
    step(2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, acc);
    idle(3);

    // Requester 1 alone on consecutive cycles: the slot refills on every grant.
    for (int a = 20; a < 26; a++) step(2'b10, 5'd0, 5'(a), 32'h0, 32'hA5A50000 | 32'(a), acc);
    idle(3);

    // Reset with r6 in the write stage and r7/r8 buffered.
    step(2'b01, 5'd6, 5'd0, 32'h66, 32'h0, acc);
    step(2'b11, 5'd7, 5'd8, 32'h77, 32'h88, acc);
    @(posedge Clock);
    #2;
    chk("pre_rst_wr_enable", 64'(WriteControl), 64'(1));
    chk("pre_rst_pending", 64'(PendingRegs), 64'(32'h0000_01C0));
    doReset(2'b00);
    idle(4);

    // Randomized traffic with disjoint address ranges per requester and a mid-run reset.
    for (int c = 0; c < 400; c++) begin
      step(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(8, 15)),
           $urandom, $urandom, acc);
      if (c == 200) doReset(2'($urandom_range(0, 3)));
    end
    idle(4);
    chk("drained", 64'(expQ.size()), 64'(0));
    for (int r = 0; r < 32; r++) chk($sformatf("rf_r%0d", r), 64'(rf[r]), 64'(expRf[r]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
